clk_div_ctrl: RTL and testbench
===============================

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of divisor and internal period counter.
REQ-002 Parameter DEFAULT_DIV, default 10, divisor loaded at reset; SHALL be in range 2..2^CNT_W-1.
REQ-003 Port clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port en  input  1  level; 1 = run divider, 0 = stop.
REQ-006 Port cfg_valid  input  1  new divisor offered.
REQ-007 Port cfg_div  input  CNT_W  offered divisor, sampled when cfg_valid and cfg_ready are both 1.
REQ-008 Port cfg_ready  output  1  controller can accept a divisor.
REQ-009 Port cfg_err  output  1  one-cycle pulse: accepted divisor was illegal (<2) and was discarded.
REQ-010 Port clk_div_o  output  1  divided clock, flop output, glitch-free.
REQ-011 Port tick_o  output  1  one-cycle pulse on the last cycle of each divided period.
REQ-012 Port div_act_o  output  CNT_W  divisor currently in effect.

Function
REQ-013 The block SHALL use three states: IDLE (stopped), RUN (counting), PEND (counting, new divisor held for the period boundary).
REQ-014 A handshake occurs in a cycle where cfg_valid=1 and cfg_ready=1; cfg_ready SHALL be 1 in IDLE and RUN and 0 in PEND.
REQ-015 A handshake with cfg_div<2 SHALL pulse cfg_err in the next cycle and leave state, div_act_o and the counter unchanged.
REQ-016 A legal handshake in IDLE SHALL load div_act_o on the next edge.
REQ-017 A legal handshake in RUN SHALL store cfg_div in a pending register and enter PEND.
REQ-018 IDLE->RUN SHALL occur on the first edge with en=1; the counter SHALL be 0 in the first RUN cycle.
REQ-019 In RUN/PEND the counter SHALL increment each cycle and wrap to 0 after value div_act_o-1.
REQ-020 Let H=(div_act_o+1)>>1. In every cycle, clk_div_o SHALL equal (cnt >= H) for the counter value of that same cycle, registered from next-state logic. Period = div_act_o cycles; low for H cycles, then high.
REQ-021 tick_o SHALL be 1 exactly in cycles where the counter equals div_act_o-1 in RUN/PEND.
REQ-022 In PEND, on the edge where the counter wraps, div_act_o SHALL take the pending value, the counter SHALL go to 0, and the state SHALL return to RUN; the period in progress completes with the old divisor.
REQ-023 en=0 in RUN/PEND SHALL enter IDLE on the next edge: counter 0, clk_div_o 0, tick_o 0. Any pending divisor SHALL be applied to div_act_o on that edge.
REQ-024 A simultaneous en fall and legal handshake in RUN SHALL apply cfg_div to div_act_o on the edge into IDLE.
REQ-025 div_act_o=2 SHALL give clk_div_o toggling every cycle and tick_o high every second cycle.
REQ-026 Counter arithmetic SHALL be CNT_W wide unsigned; the maximum divisor, 2^CNT_W-1, SHALL wrap correctly with no overflow.

Reset
REQ-027 While rst_n=0: state IDLE, counter 0, div_act_o=DEFAULT_DIV, pending register 0, clk_div_o=0, tick_o=0, cfg_err=0, cfg_ready=1.
REQ-028 Reset assertion mid-period or in PEND SHALL abort immediately and discard the pending divisor.

Verification
REQ-029 Reset, then en=1 with default 10 -> clk_div_o low 5 and high 5 cycles; tick_o every 10th cycle, first at counter=9.
REQ-030 Handshake cfg_div=3 in IDLE, then en=1 -> period 3: low 2 cycles, high 1 cycle; tick_o every 3 cycles.
REQ-031 Running at 10, handshake cfg_div=4 at counter=2 -> cfg_ready=0 until the wrap after counter=9; the next period is 4 cycles; div_act_o=4 from that edge.
REQ-032 Handshake cfg_div=1 (also 0) -> cfg_err pulses for 1 cycle; div_act_o and the waveform are unchanged.
REQ-033 en falls while in PEND (pending 6) -> IDLE next edge, clk_div_o=0, div_act_o=6; re-enable gives period 6 from counter 0.
REQ-034 rst_n pulsed low at counter=7 of a 10-cycle period -> all outputs at reset values asynchronously; div_act_o=10.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable clock divider with a ready/valid divisor load port.
// A new divisor is accepted at any time and takes effect at the next period
// boundary, so the output waveform never shows a truncated or stretched period.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst_n      asynchronous active-low reset
//   en         level enable: 1 runs the divider, 0 stops it
//   cfg_valid  divisor offered on cfg_div
//   cfg_div    offered divisor (CNT_W bits), must be >= 2
//   cfg_ready  controller can accept a divisor (low while one is pending)
//   cfg_err    one-cycle pulse after an illegal (<2) divisor was accepted and dropped
//   clk_div_o  divided clock: low for ceil(div/2) cycles, then high
//   tick_o     one-cycle pulse on the last cycle of each divided period
//   div_act_o  divisor currently in effect
module clk_div_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DEFAULT_DIV = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_div_o,
  output logic             tick_o,
  output logic [CNT_W-1:0] div_act_o
);

  localparam int unsigned EXT_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] half_d;
  logic             hs_c;
  logic             legal_c;
  logic             wrap_c;
  logic             run_d;
  logic             clk_div_d;
  logic             tick_d;
  logic             err_d;

  // State, counter and divisor registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_act_o <= DIV_RST;
      pend_q    <= '0;
      clk_div_o <= 1'b0;
      tick_o    <= 1'b0;
      cfg_err   <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_act_o <= div_d;
      pend_q    <= pend_d;
      clk_div_o <= clk_div_d;
      tick_o    <= tick_d;
      cfg_err   <= err_d;
      cfg_ready <= (state_d != PEND);
    end
  end

  // Next-state, counter and output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_act_o;
    pend_d  = pend_q;

    hs_c    = cfg_valid && cfg_ready;
    legal_c = (cfg_div >= CNT_W'(2));
    wrap_c  = (cnt_q == div_act_o - CNT_W'(1));
    err_d   = hs_c && !legal_c;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (hs_c && legal_c) div_d = cfg_div;
        if (en) state_d = RUN;
      end
      RUN: begin
        if (!en) begin
          // Stopping: a divisor offered on the same edge lands directly
          state_d = IDLE;
          cnt_d   = '0;
          if (hs_c && legal_c) div_d = cfg_div;
        end else begin
          cnt_d = wrap_c ? '0 : cnt_q + CNT_W'(1);
          if (hs_c && legal_c) begin
            pend_d  = cfg_div;
            state_d = PEND;
          end
        end
      end
      PEND: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
          div_d   = pend_q;
        end else if (wrap_c) begin
          // Period boundary: switch to the held divisor
          state_d = RUN;
          cnt_d   = '0;
          div_d   = pend_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from next-cycle values so the flops match that cycle's counter;
    // the half-period sum is one bit wider so the maximum divisor cannot overflow
    run_d     = (state_d != IDLE);
    half_d    = CNT_W'((EXT_W'(div_d) + EXT_W'(1)) >> 1);
    clk_div_d = run_d && (cnt_d >= half_d);
    tick_d    = run_d && (cnt_d == div_d - CNT_W'(1));
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: a driver issues per-cycle stimulus and
// pushes the reference model's expected outputs; a monitor pops and compares.
module tb_clk_div_ctrl;

  localparam int unsigned W  = 16;
  localparam int unsigned SW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          cfg_valid;
  logic [W-1:0]  cfg_div;
  logic          cfg_ready;
  logic          cfg_err;
  logic          clk_div_o;
  logic          tick_o;
  logic [W-1:0]  div_act_o;

  logic          s_en;
  logic          s_cfg_valid;
  logic [SW-1:0] s_cfg_div;
  logic          s_cfg_ready;
  logic          s_cfg_err;
  logic          s_clk_div;
  logic          s_tick;
  logic [SW-1:0] s_div_act;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  clk_div_ctrl #(.CNT_W(W), .DEFAULT_DIV(10)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .clk_div_o(clk_div_o),
    .tick_o(tick_o), .div_act_o(div_act_o)
  );

  // Narrow instance: maximum divisor 2^4-1 exercises counter wrap at full width
  clk_div_ctrl #(.CNT_W(SW), .DEFAULT_DIV(15)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(s_en), .cfg_valid(s_cfg_valid), .cfg_div(s_cfg_div),
    .cfg_ready(s_cfg_ready), .cfg_err(s_cfg_err), .clk_div_o(s_clk_div),
    .tick_o(s_tick), .div_act_o(s_div_act)
  );

  typedef struct {
    bit clk_div;
    bit tick;
    bit rdy;
    bit err;
    int div;
  } exp_t;

  exp_t sb[$];

  // Reference model: position within the current period plus divisor bookkeeping
  bit m_run;
  bit m_pv;
  int m_div;
  int m_pend;
  int m_pos;
  bit m_err;

  function automatic void chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.clk_div = m_run && (m_pos >= (m_div + 1) / 2);
    e.tick    = m_run && (m_pos == m_div - 1);
    e.rdy     = !m_pv;
    e.err     = m_err;
    e.div     = m_div;
    return e;
  endfunction

  function automatic void model_reset();
    m_run = 0; m_pv = 0; m_div = 10; m_pend = 0; m_pos = 0; m_err = 0;
  endfunction

  // Advance the model across one rising edge with the given inputs
  function automatic void model_step(input bit e, input bit v, input int d);
    bit hs, take;
    hs    = v && !m_pv;
    take  = hs && (d >= 2);
    m_err = hs && (d < 2);
    if (!m_run) begin
      if (take) m_div = d;
      if (e) begin m_run = 1; m_pos = 0; end
    end else if (!e) begin
      m_run = 0;
      m_pos = 0;
      if (m_pv) begin m_div = m_pend; m_pv = 0; end
      else if (take) m_div = d;
    end else begin
      if (m_pos == m_div - 1) begin
        m_pos = 0;
        if (m_pv) begin m_div = m_pend; m_pv = 0; end
      end else begin
        m_pos++;
      end
      if (take) begin m_pend = d; m_pv = 1; end
    end
  endfunction

  task automatic step(input bit e, input bit v, input int d);
    @(negedge clk);
    rst_n     = 1'b1;
    en        = e;
    cfg_valid = v;
    cfg_div   = W'(d);
    model_step(e, v, d);
    sb.push_back(model_out());
  endtask

  // Asynchronous reset asserted mid low phase; outputs checked before any edge
  task automatic do_reset();
    @(negedge clk);
    sb.delete();
    #2;
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    #1;
    chk("rst_clk_div", clk_div_o, 0);
    chk("rst_tick", tick_o, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_div", div_act_o, 10);
    model_reset();
    sb.push_back(model_out());
  endtask

  task automatic run_to_pos(input int p);
    for (int i = 0; i < 70 && m_pos != p; i++) step(1, 0, 0);
  endtask

  // Monitor: one output set per cycle, sampled just after the rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("clk_div_o", clk_div_o, e.clk_div);
        chk("tick_o", tick_o, e.tick);
        chk("cfg_ready", cfg_ready, e.rdy);
        chk("cfg_err", cfg_err, e.err);
        chk("div_act_o", div_act_o, e.div);
      end
    end
  end

  initial begin
    int ticks[$];
    int highs;
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    s_en = 1'b0; s_cfg_valid = 1'b0; s_cfg_div = '0;
    model_reset();

    do_reset();
    repeat (25) step(1, 0, 0);            // default divisor 10

    run_to_pos(2);
    step(1, 1, 4);                        // held until the wrap after count 9
    repeat (20) step(1, 0, 0);

    step(1, 1, 1);                        // illegal divisors
    step(1, 0, 0);
    step(1, 1, 0);
    repeat (8) step(1, 0, 0);

    step(1, 1, 6);                        // pending 6, then stop
    step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    repeat (15) step(1, 0, 0);

    step(0, 1, 5);                        // en falls with a handshake
    repeat (2) step(0, 0, 0);
    step(0, 1, 3);                        // load in IDLE
    repeat (10) step(1, 0, 0);
    step(0, 1, 2);                        // minimum divisor
    repeat (8) step(1, 0, 0);

    step(0, 1, 10);
    repeat (3) step(1, 0, 0);
    run_to_pos(7);
    do_reset();                           // mid-period reset
    repeat (12) step(1, 0, 0);
    step(1, 1, 3);
    repeat (4) step(1, 0, 0);
    step(1, 1, 5);
    step(1, 0, 0);
    do_reset();                           // reset discards the pending divisor
    repeat (14) step(1, 0, 0);

    for (int i = 0; i < 600; i++) begin
      int r, d;
      r = int'($urandom_range(0, 9));
      d = (r == 0) ? 0 : (r == 1) ? 1 : int'($urandom_range(2, 20));
      if ($urandom_range(0, 199) == 0) do_reset();
      else step($urandom_range(0, 19) != 0, $urandom_range(0, 7) == 0, d);
    end
    step(0, 0, 0);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    // Full-width divisor on the narrow instance
    @(negedge clk);
    s_en  = 1'b1;
    highs = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      #1;
      if (s_tick) ticks.push_back(i);
      if (s_clk_div) highs++;
    end
    s_en = 1'b0;
    chk("max_div_act", s_div_act, 15);
    chk("max_tick_count", ticks.size(), 3);
    if (ticks.size() == 3) begin
      chk("max_tick0", ticks[0], 14);
      chk("max_tick1", ticks[1], 29);
      chk("max_tick2", ticks[2], 44);
    end
    chk("max_high_cycles", highs, 21);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
